// File: rtl/hack_sequencer_if.sv
// Bundle of the fetch, memory and datapath-control signals between the HACK
// sequencer (master) and the datapath / memories around it (slave).
interface hack_seq_if;
    logic        instr_req;
    logic        instr_ack;
    logic [15:0] instr;
    logic [14:0] imm;
    logic        a_sel_imm;
    logic        a_load;
    logic        d_load;
    logic        pc_inc;
    logic        pc_load;
    logic [5:0]  alu_ctl;
    logic        alu_sel_m;
    logic        zr;
    logic        ng;
    logic        m_rd_req;
    logic        m_wr_req;
    logic        m_ack;

    modport master (
        output instr_req, imm, a_sel_imm, a_load, d_load, pc_inc, pc_load,
               alu_ctl, alu_sel_m, m_rd_req, m_wr_req,
        input  instr_ack, instr, zr, ng, m_ack
    );

    modport slave (
        input  instr_req, imm, a_sel_imm, a_load, d_load, pc_inc, pc_load,
               alu_ctl, alu_sel_m, m_rd_req, m_wr_req,
        output instr_ack, instr, zr, ng, m_ack
    );
endinterface

// File: rtl/hack_sequencer.sv
// Multi-cycle HACK CPU control unit: fetch, decode, memory handshakes, commit.
// Optional single-step gating of the fetch is enabled by defining HACK_SEQ_STEP_EN.
module hack_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef HACK_SEQ_STEP_EN
    input  logic             step,
`endif
    hack_seq_if.master       bus,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        RD_WAIT = 3'd2,
        EXEC    = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic instr_req_c, m_rd_req_c, m_wr_req_c;
    logic a_load_c, a_sel_imm_c, d_load_c, pc_inc_c, pc_load_c;
    logic commit_c, jump_c, fetch_go_c;

`ifdef HACK_SEQ_STEP_EN
    // Remembers a sampled step pulse until the fetch it unlocks is accepted.
    logic go_q, go_d;
    assign fetch_go_c = go_q;
`else
    assign fetch_go_c = 1'b1;
`endif

    assign jump_c = (ir_q[2] & bus.ng) | (ir_q[1] & bus.zr) |
                    (ir_q[0] & ~bus.zr & ~bus.ng);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        instr_req_c = 1'b0;
        m_rd_req_c  = 1'b0;
        m_wr_req_c  = 1'b0;
        a_load_c    = 1'b0;
        a_sel_imm_c = 1'b0;
        d_load_c    = 1'b0;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        commit_c    = 1'b0;
`ifdef HACK_SEQ_STEP_EN
        go_d        = go_q;
`endif

        case (state_q)
            FETCH: begin
`ifdef HACK_SEQ_STEP_EN
                if (!go_q) begin
                    go_d = step;
                end
`endif
                if (fetch_go_c) begin
                    instr_req_c = 1'b1;
                    if (bus.instr_ack) begin
                        ir_d    = bus.instr;
                        state_d = DECODE;
`ifdef HACK_SEQ_STEP_EN
                        go_d    = 1'b0;
`endif
                    end
                end
            end
            DECODE: begin
                if (!ir_q[15]) begin
                    a_load_c    = 1'b1;
                    a_sel_imm_c = 1'b1;
                    pc_inc_c    = 1'b1;
                    retired_d   = retired_q + CNT_W'(1);
                    state_d     = FETCH;
                end else if (ir_q[12]) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = EXEC;
                end
            end
            RD_WAIT: begin
                m_rd_req_c = 1'b1;
                if (bus.m_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ir_q[3]) begin
                    m_wr_req_c = 1'b1;
                    state_d    = WR_WAIT;
                end else begin
                    commit_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            WR_WAIT: begin
                m_wr_req_c = 1'b1;
                if (bus.m_ack) begin
                    commit_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // A and memory address use pre-edge A, so an A-write plus jump is safe.
        if (commit_c) begin
            a_load_c  = ir_q[5];
            d_load_c  = ir_q[4];
            pc_load_c = jump_c;
            pc_inc_c  = ~jump_c;
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

`ifdef HACK_SEQ_STEP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go_d;
        end
    end
`endif

    // Strobes and requests are forced low while reset is held so nothing commits.
    assign bus.instr_req = instr_req_c & rst_n;
    assign bus.m_rd_req  = m_rd_req_c  & rst_n;
    assign bus.m_wr_req  = m_wr_req_c  & rst_n;
    assign bus.a_load    = a_load_c    & rst_n;
    assign bus.a_sel_imm = a_sel_imm_c & rst_n;
    assign bus.d_load    = d_load_c    & rst_n;
    assign bus.pc_inc    = pc_inc_c    & rst_n;
    assign bus.pc_load   = pc_load_c   & rst_n;

    assign bus.imm       = ir_q[14:0];
    assign bus.alu_ctl   = ir_q[11:6];
    assign bus.alu_sel_m = ir_q[12];
    assign state         = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_hack_sequencer.sv
// Scoreboard bench for hack_sequencer: stimulus queues expected commit-cycle
// outputs, a monitor pops and compares them whenever a commit strobe appears.
module tb_hack_sequencer;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
`ifdef HACK_SEQ_STEP_EN
    logic             step;
`endif

    always #5 clk = ~clk;

    hack_seq_if bus ();

    hack_sequencer #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef HACK_SEQ_STEP_EN
        .step    (step),
`endif
        .bus     (bus),
        .state   (state),
        .retired (retired)
    );

    // {a_load, a_sel_imm, d_load, pc_inc, pc_load, alu_sel_m, alu_ctl, imm, retired}
    typedef logic [30:0] exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_commit = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] w, input logic al, input logic ai,
                                input logic dl, input logic pi, input logic pl,
                                input logic [CNT_W-1:0] r);
        return {al, ai, dl, pi, pl, w[12], w[11:6], w[14:0], r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every commit-cycle strobe pattern must match the next queued entry.
    initial begin
        exp_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.a_load | bus.d_load | bus.pc_inc | bus.pc_load) begin
                act = {bus.a_load, bus.a_sel_imm, bus.d_load, bus.pc_inc, bus.pc_load,
                       bus.alu_sel_m, bus.alu_ctl, bus.imm, retired};
                n_commit++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: got %h, expected no commit", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit", {33'd0, act}, {33'd0, e});
                    $display("commit %0d: outputs %h, expected %h", n_commit, act, e);
                end
            end
        end
    end

    // sel: 0 = fetch request, 1 = read wait state, 2 = write wait state
    task automatic wait_for(input int sel, input string nm);
        int  t;
        logic hit;
        t = 0;
        hit = 1'b0;
        while (!hit && t < 64) begin
            case (sel)
                0:       hit = bus.instr_req;
                1:       hit = (state == 3'd2);
                default: hit = (state == 3'd4);
            endcase
            if (sel == 2 && state == 3'd3) chk("wr_req_in_exec", {63'd0, bus.m_wr_req}, 64'd1);
            if (!hit) begin
                tick;
                t++;
            end
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: got no event in 64 cycles, expected one", nm);
        end
    endtask

    task automatic mem_hs(input int sel, input int waits);
        wait_for(sel, sel == 1 ? "rd" : "wr");
        for (int i = 0; i < waits; i++) begin
            chk(sel == 1 ? "rd_req_held" : "wr_req_held",
                {63'd0, (sel == 1) ? bus.m_rd_req : bus.m_wr_req}, 64'd1);
            tick;
        end
        bus.m_ack = 1'b1;
        tick;
        bus.m_ack = 1'b0;
        chk(sel == 1 ? "rd_req_drop" : "wr_req_drop",
            {63'd0, (sel == 1) ? bus.m_rd_req : bus.m_wr_req}, 64'd0);
    endtask

    task automatic run_instr(input logic [15:0] w, input int fw, input int rw, input int ww,
                             input logic z, input logic n, input exp_t e);
        int t;
        exp_q.push_back(e);
        bus.zr = z;
        bus.ng = n;
        wait_for(0, "fetch");
        for (int i = 0; i < fw; i++) begin
            chk("fetch_req_held", {63'd0, bus.instr_req}, 64'd1);
            tick;
        end
        bus.instr_ack = 1'b1;
        bus.instr     = w;
        tick;
        bus.instr_ack = 1'b0;
        bus.instr     = 16'hBEEF;
        chk("fetch_req_drop", {63'd0, bus.instr_req}, 64'd0);
        if (w[15] && w[12]) mem_hs(1, rw);
        if (w[15] && w[3])  mem_hs(2, ww);
        t = 0;
        while (state != 3'd0 && t < 16) begin
            tick;
            t++;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.instr_ack = 1'b0;
        bus.m_ack     = 1'b0;
        bus.instr     = 16'h0000;
        bus.zr        = 1'b0;
        bus.ng        = 1'b0;
`ifdef HACK_SEQ_STEP_EN
        step          = 1'b1;
`endif
        // Reset held 3 cycles with acks toggling
        for (int i = 0; i < 3; i++) begin
            tick;
            bus.instr_ack = ~bus.instr_ack;
            bus.m_ack     = ~bus.m_ack;
            bus.instr     = 16'hFFFF;
        end
        chk("reset_outputs", {23'd0, bus.instr_req, bus.a_sel_imm, bus.a_load, bus.d_load,
            bus.pc_inc, bus.pc_load, bus.alu_ctl, bus.alu_sel_m, bus.m_rd_req, bus.m_wr_req,
            bus.imm}, 64'd0);
        chk("reset_state", {61'd0, state}, 64'd0);
        chk("reset_retired", {60'd0, retired}, 64'd0);
        bus.instr_ack = 1'b0;
        bus.m_ack     = 1'b0;
        tick;
        rst_n = 1'b1;

        // Directed vectors: word, fetch/read/write waits, zr, ng, expected commit
        run_instr(16'h1234, 0, 0, 0, 0, 0, mk(16'h1234, 1, 1, 0, 1, 0, 4'd0));
        chk("retired_after_a", {60'd0, retired}, 64'd1);
        run_instr(16'hFDD1, 1, 3, 0, 0, 0, mk(16'hFDD1, 0, 0, 1, 0, 1, 4'd1));
        run_instr(16'hFDD1, 0, 3, 0, 0, 1, mk(16'hFDD1, 0, 0, 1, 1, 0, 4'd2));
        run_instr(16'hE328, 0, 0, 2, 0, 0, mk(16'hE328, 1, 0, 0, 1, 0, 4'd3));
        run_instr(16'hFDC8, 2, 0, 0, 0, 0, mk(16'hFDC8, 0, 0, 0, 1, 0, 4'd4));
        run_instr(16'hE000, 0, 0, 0, 0, 0, mk(16'hE000, 0, 0, 0, 1, 0, 4'd5));
        run_instr(16'hEA87, 0, 0, 0, 1, 0, mk(16'hEA87, 0, 0, 0, 0, 1, 4'd6));
        run_instr(16'hE322, 0, 0, 0, 1, 0, mk(16'hE322, 1, 0, 0, 0, 1, 4'd7));
        run_instr(16'hE304, 0, 0, 0, 0, 1, mk(16'hE304, 0, 0, 0, 0, 1, 4'd8));
        run_instr(16'hE304, 0, 0, 0, 0, 0, mk(16'hE304, 0, 0, 0, 1, 0, 4'd9));
        chk("retired_after_vectors", {60'd0, retired}, 64'd10);

        // Reset pulled during RD_WAIT: request drops, nothing commits
        wait_for(0, "fetch_midreset");
        bus.instr_ack = 1'b1;
        bus.instr     = 16'hFDD1;
        tick;
        bus.instr_ack = 1'b0;
        tick;
        chk("midreset_in_rd_wait", {61'd0, state}, 64'd2);
        chk("midreset_rd_req_before", {63'd0, bus.m_rd_req}, 64'd1);
        rst_n     = 1'b0;
        bus.m_ack = 1'b1;
        tick;
        bus.m_ack = 1'b0;
        chk("midreset_rd_req", {63'd0, bus.m_rd_req}, 64'd0);
        chk("midreset_d_load", {63'd0, bus.d_load}, 64'd0);
        chk("midreset_state", {61'd0, state}, 64'd0);
        chk("midreset_retired", {60'd0, retired}, 64'd0);
        tick;
        rst_n = 1'b1;

        // Counter wrap: 16 A-instructions on a 4-bit counter
        for (int k = 0; k < 16; k++) begin
            logic [15:0] w;
            logic [3:0]  r;
            w = 16'h0100 + 16'(k);
            r = 4'(k);
            run_instr(w, 0, 0, 0, 0, 0, mk(w, 1, 1, 0, 1, 0, r));
        end
        chk("retired_wrap", {60'd0, retired}, 64'd0);

`ifdef HACK_SEQ_STEP_EN
        step = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) begin
            chk("step_idle_req", {63'd0, bus.instr_req}, 64'd0);
            tick;
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        run_instr(16'h0042, 0, 0, 0, 0, 0, mk(16'h0042, 1, 1, 0, 1, 0, 4'd0));
        for (int i = 0; i < 10; i++) begin
            chk("step_after_req", {63'd0, bus.instr_req}, 64'd0);
            tick;
        end
        chk("step_retired", {60'd0, retired}, 64'd1);
`endif

        repeat (3) tick;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
